ca_code_gen: RTL and testbench

Generates the GPS L1 C/A spreading code for one channel. Implements the G1/G2 Gold-code LFSR pair with per-PRN G2 phase-select taps, and advances one chip per `chip_en` strobe from the code NCO. Its `code` output is the early replica. This block sits directly upstream of the channel's chip-delay line, which derives the prompt and late replicas from it. It also supplies the chip index and epoch markers used by the correlator dump logic.

---
 rtl/ca_code_gen.sv | 134 +++++++++++++
 tb/tb_ca_code_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_code_gen.sv
// GPS L1 C/A Gold-code generator (G1/G2 LFSR pair) for one tracking channel.
// Optional nav-bit epoch counter enabled by defining CA_GEN_EPOCH_COUNT_EN.
module ca_code_gen #(
  parameter int CODE_LENGTH = 1023,
  parameter int PRN_WIDTH   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [PRN_WIDTH-1:0] prn,
  input  logic                 chip_en,
  output logic                 code,
  output logic [9:0]           chip_index,
  output logic                 epoch,
  output logic                 valid,
  output logic [4:0]           epoch_count
);

  localparam logic [9:0] LAST_CHIP = 10'(CODE_LENGTH - 1);

  function automatic logic prn_legal(input logic [PRN_WIDTH-1:0] p);
    int unsigned v;
    v = 32'(p);
    return (v >= 1) && (v <= 32);
  endfunction

  // Returns {s1, s2}: the two G2 stages XORed to form the PRN's phase shift.
  function automatic logic [7:0] phase_taps(input logic [PRN_WIDTH-1:0] p);
    int unsigned v;
    v = 32'(p);
    case (v)
      1:  return {4'd2, 4'd6};
      2:  return {4'd3, 4'd7};
      3:  return {4'd4, 4'd8};
      4:  return {4'd5, 4'd9};
      5:  return {4'd1, 4'd9};
      6:  return {4'd2, 4'd10};
      7:  return {4'd1, 4'd8};
      8:  return {4'd2, 4'd9};
      9:  return {4'd3, 4'd10};
      10: return {4'd2, 4'd3};
      11: return {4'd3, 4'd4};
      12: return {4'd5, 4'd6};
      13: return {4'd6, 4'd7};
      14: return {4'd7, 4'd8};
      15: return {4'd8, 4'd9};
      16: return {4'd9, 4'd10};
      17: return {4'd1, 4'd4};
      18: return {4'd2, 4'd5};
      19: return {4'd3, 4'd6};
      20: return {4'd4, 4'd7};
      21: return {4'd5, 4'd8};
      22: return {4'd6, 4'd9};
      23: return {4'd1, 4'd3};
      24: return {4'd4, 4'd6};
      25: return {4'd5, 4'd7};
      26: return {4'd6, 4'd8};
      27: return {4'd7, 4'd9};
      28: return {4'd8, 4'd10};
      29: return {4'd1, 4'd6};
      30: return {4'd2, 4'd7};
      31: return {4'd3, 4'd8};
      32: return {4'd4, 4'd9};
      default: return {4'd1, 4'd1};
    endcase
  endfunction

  logic [1:10]          g1;
  logic [1:10]          g2;
  logic [PRN_WIDTH-1:0] prn_q;
  logic [3:0]           s1;
  logic [3:0]           s2;
  logic                 g1_fb;
  logic                 g2_fb;
  logic                 at_last;

  assign g1_fb   = g1[3] ^ g1[10];
  assign g2_fb   = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
  assign at_last = (chip_index == LAST_CHIP);
  assign {s1, s2} = phase_taps(prn_q);
  assign code    = valid & (g1[10] ^ g2[s1] ^ g2[s2]);

  // Wrap reloads the LFSRs so shortened test lengths still restart at chip 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g1         <= '1;
      g2         <= '1;
      chip_index <= '0;
      prn_q      <= '0;
      valid      <= 1'b0;
      epoch      <= 1'b0;
    end else if (init) begin
      g1         <= '1;
      g2         <= '1;
      chip_index <= '0;
      prn_q      <= prn;
      valid      <= prn_legal(prn);
      epoch      <= prn_legal(prn);
    end else begin
      epoch <= 1'b0;
      if (chip_en) begin
        if (at_last) begin
          g1         <= '1;
          g2         <= '1;
          chip_index <= '0;
          epoch      <= valid;
        end else begin
          g1         <= {g1_fb, g1[1:9]};
          g2         <= {g2_fb, g2[1:9]};
          chip_index <= chip_index + 10'd1;
        end
      end
    end
  end

`ifdef CA_GEN_EPOCH_COUNT_EN
  logic [4:0] epoch_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epoch_cnt <= '0;
    end else if (init) begin
      epoch_cnt <= '0;
    end else if (chip_en && at_last && valid) begin
      epoch_cnt <= (epoch_cnt == 5'd19) ? 5'd0 : epoch_cnt + 5'd1;
    end
  end

  assign epoch_count = epoch_cnt;
`else
  assign epoch_count = '0;
`endif

endmodule

// File: tb/tb_ca_code_gen.sv
// Self-checking bench for ca_code_gen: reset, PRN 1..3 code starts, full period,
// init precedence, illegal PRNs and the epoch counter (CA_GEN_EPOCH_COUNT_EN).
module tb_ca_code_gen;

  localparam int CL = 1023;
`ifdef CA_GEN_EPOCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init = 1'b0;
  logic [5:0] prn = '0;
  logic       chip_en = 1'b0;
  logic       code;
  logic [9:0] chip_index;
  logic       epoch;
  logic       valid;
  logic [4:0] epoch_count;

  int n_pass = 0;
  int n_total = 0;
  bit exp_q[$];

  ca_code_gen #(.CODE_LENGTH(CL), .PRN_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .init(init), .prn(prn), .chip_en(chip_en),
    .code(code), .chip_index(chip_index), .epoch(epoch), .valid(valid),
    .epoch_count(epoch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [5:0] p, input logic ce);
    init = 1'b1;
    prn = p;
    chip_en = ce;
    tick();
    init = 1'b0;
    chip_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    tick();
    tick();
    obs = {code, chip_index, epoch, valid, epoch_count};
    n_total++;
    if (obs !== 18'b0) $display("FAIL reset_initial outputs=%h expected=0", obs);
    else n_pass++;
    reset = 1'b1;
    tick();
    do_init(6'd1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chip_en = (i % 2 == 0);
      tick();
    end
    #2;
    reset = 1'b0;
    #1;
    obs = {code, chip_index, epoch, valid, epoch_count};
    n_total++;
    if (obs !== 18'b0) $display("FAIL reset_async outputs=%h expected=0", obs);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      chip_en = (i % 2 == 0);
      tick();
      obs = {code, chip_index, epoch, valid, epoch_count};
      n_total++;
      if (obs !== 18'b0) $display("FAIL reset_held%0d outputs=%h expected=0", i, obs);
      else n_pass++;
    end
    reset = 1'b1;
    chip_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chip_en = 1'b0;
    n_total++;
    if ({valid, code} !== 2'b00) $display("FAIL reset_no_init valid=%b code=%b expected 0 0", valid, code);
    else n_pass++;
  endtask

  task automatic test_prn_chips(input logic [5:0] p, input logic [9:0] oct);
    bit e;
    for (int i = 9; i >= 0; i--) exp_q.push_back(oct[i]);
    do_init(p, 1'b0);
    for (int k = 0; k < 10; k++) begin
      e = exp_q.pop_front();
      n_total++;
      if (code !== e) $display("FAIL prn%0d_chip%0d code=%b expected=%b", p, k, code, e);
      else n_pass++;
      n_total++;
      if (epoch !== (k == 0)) $display("FAIL prn%0d_epoch%0d epoch=%b expected=%b", p, k, epoch, (k == 0));
      else n_pass++;
      n_total++;
      if (chip_index !== 10'(k)) $display("FAIL prn%0d_index%0d index=%0d expected=%0d", p, k, chip_index, k);
      else n_pass++;
      chip_en = 1'b1;
      tick();
    end
    chip_en = 1'b0;
  endtask

  task automatic test_full_period();
    int ones = 0;
    int epochs = 0;
    int idx_err = 0;
    bit e;
    do_init(6'd1, 1'b0);
    for (int i = 9; i >= 0; i--) exp_q.push_back(i inside {9, 8, 5});
    for (int k = 0; k <= CL + 9; k++) begin
      if (k < CL && code) ones++;
      if (k >= 1 && k <= CL && epoch) epochs++;
      if (k < CL && chip_index !== 10'(k)) idx_err++;
      if (k == CL) begin
        n_total++;
        if (chip_index !== 10'd0) $display("FAIL period_wrap_index index=%0d expected=0", chip_index);
        else n_pass++;
        n_total++;
        if (epoch !== 1'b1) $display("FAIL period_wrap_epoch epoch=%b expected=1", epoch);
        else n_pass++;
      end
      if (k == CL + 1) begin
        n_total++;
        if (epoch !== 1'b0) $display("FAIL period_epoch_width epoch=%b expected=0", epoch);
        else n_pass++;
      end
      if (k >= CL) begin
        e = exp_q.pop_front();
        n_total++;
        if (code !== e) $display("FAIL period2_chip%0d code=%b expected=%b", k - CL, code, e);
        else n_pass++;
      end
      chip_en = 1'b1;
      tick();
    end
    chip_en = 1'b0;
    n_total++;
    if (ones != 512) $display("FAIL period_ones count=%0d expected=512", ones);
    else n_pass++;
    n_total++;
    if (epochs != 1) $display("FAIL period_epochs count=%0d expected=1", epochs);
    else n_pass++;
    n_total++;
    if (idx_err != 0) $display("FAIL period_index_track errors=%0d expected=0", idx_err);
    else n_pass++;
  endtask

  task automatic test_init_precedence();
    do_init(6'd1, 1'b0);
    chip_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    do_init(6'd2, 1'b1);
    n_total++;
    if (chip_index !== 10'd0) $display("FAIL prec_index index=%0d expected=0", chip_index);
    else n_pass++;
    n_total++;
    if ({valid, epoch, code} !== 3'b111) $display("FAIL prec_flags valid_epoch_code=%b expected=111", {valid, epoch, code});
    else n_pass++;
    chip_en = 1'b1;
    tick();
    chip_en = 1'b0;
    n_total++;
    if (chip_index !== 10'd1) $display("FAIL prec_resume index=%0d expected=1", chip_index);
    else n_pass++;
  endtask

  task automatic test_invalid_prn(input logic [5:0] p);
    bit code_seen = 1'b0;
    bit epoch_seen = 1'b0;
    do_init(p, 1'b0);
    n_total++;
    if (valid !== 1'b0) $display("FAIL bad%0d_valid valid=%b expected=0", p, valid);
    else n_pass++;
    for (int k = 0; k <= CL + 1; k++) begin
      if (code) code_seen = 1'b1;
      if (epoch) epoch_seen = 1'b1;
      if (k == CL) begin
        n_total++;
        if (chip_index !== 10'd0) $display("FAIL bad%0d_wrap index=%0d expected=0", p, chip_index);
        else n_pass++;
      end
      chip_en = 1'b1;
      tick();
    end
    chip_en = 1'b0;
    n_total++;
    if (code_seen !== 1'b0) $display("FAIL bad%0d_code seen=%b expected=0", p, code_seen);
    else n_pass++;
    n_total++;
    if (epoch_seen !== 1'b0) $display("FAIL bad%0d_epoch seen=%b expected=0", p, epoch_seen);
    else n_pass++;
    n_total++;
    if (epoch_count !== 5'd0) $display("FAIL bad%0d_count count=%0d expected=0", p, epoch_count);
    else n_pass++;
  endtask

  task automatic test_epoch_count();
    int wraps = 0;
    int nwraps;
    logic [4:0] exp;
    nwraps = CNT_EN ? 21 : 2;
    do_init(6'd5, 1'b0);
    n_total++;
    if (epoch_count !== 5'd0) $display("FAIL cnt_after_init count=%0d expected=0", epoch_count);
    else n_pass++;
    chip_en = 1'b1;
    for (int s = 1; s <= nwraps * CL; s++) begin
      tick();
      if (s % CL == 0) begin
        wraps++;
        exp = CNT_EN ? 5'(wraps % 20) : 5'd0;
        n_total++;
        if (epoch_count !== exp) $display("FAIL cnt_wrap%0d count=%0d expected=%0d", wraps, epoch_count, exp);
        else n_pass++;
      end
    end
    chip_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prn_chips(6'd1, 10'o1440);
    test_prn_chips(6'd2, 10'o1620);
    test_prn_chips(6'd3, 10'o1710);
    test_full_period();
    test_init_precedence();
    test_invalid_prn(6'd0);
    test_invalid_prn(6'd33);
    test_epoch_count();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
